// File: rtl/tick_countdown_timer.sv
// Tick-driven countdown timer: converts a toggling timebase into tick strobes and runs a
// one-shot/auto-reload countdown. Define TICK_STALL_DETECT_EN to enable the timebase-stall watchdog.
module tick_countdown_timer #(
    parameter int CNT_W        = 16,
    parameter int FREE_W       = 32,
    parameter int STALL_CYCLES = 1200000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              start,
    input  logic [CNT_W-1:0]  load_val,
    input  logic              reload,
    input  logic              abort,
    output logic              tick_pulse,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  remaining,
    output logic [FREE_W-1:0] tick_count,
    output logic              stall
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic             sync1, sync2, prev;
    logic             reload_q;
    logic [CNT_W-1:0] load_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
            tick_pulse <= 1'b0;
            tick_count <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            remaining  <= '0;
            reload_q   <= 1'b0;
            load_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments let the three flops form a true shift chain.
            sync1      <= tick_in;
            sync2      <= sync1;
            prev       <= sync2;
            tick_pulse <= sync2 ^ prev;

            if (tick_pulse)
                tick_count <= tick_count + FREE_W'(1);

            done <= 1'b0;

            // abort outranks start, which outranks a tick in the same cycle.
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                remaining <= '0;
            end else if (start) begin
                if (load_val != '0) begin
                    state     <= RUN;
                    busy      <= 1'b1;
                    remaining <= load_val;
                    load_q    <= load_val;
                    reload_q  <= reload;
                end else begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    remaining <= '0;
                    done      <= 1'b1;
                end
            end else if (state == RUN && tick_pulse) begin
                if (remaining > CNT_W'(1)) begin
                    remaining <= remaining - CNT_W'(1);
                end else begin
                    done <= 1'b1;
                    if (reload_q) begin
                        remaining <= load_q;
                    end else begin
                        remaining <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef TICK_STALL_DETECT_EN
    localparam int              WD_W   = $clog2(STALL_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_CYCLES);

    logic [WD_W-1:0] watchdog;

    // Saturating count of cycles since the last tick; stall holds until a tick clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            watchdog <= '0;
        else if (tick_pulse)
            watchdog <= '0;
        else if (watchdog != WD_MAX)
            watchdog <= watchdog + WD_W'(1);
    end

    assign stall = (watchdog == WD_MAX);
`else
    assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Scoreboard bench for tick_countdown_timer: stimulus queues expected tick/done events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_tick_countdown_timer;

    localparam int CNT_W  = 16;
    localparam int FREE_W = 32;
`ifdef TICK_STALL_DETECT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              tick_in;
    logic              start;
    logic [CNT_W-1:0]  load_val;
    logic              reload;
    logic              abort;
    logic              tick_pulse;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  remaining;
    logic [FREE_W-1:0] tick_count;
    logic              stall;

    tick_countdown_timer #(
        .CNT_W(CNT_W), .FREE_W(FREE_W), .STALL_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .load_val(load_val),
        .reload(reload), .abort(abort), .tick_pulse(tick_pulse), .busy(busy), .done(done),
        .remaining(remaining), .tick_count(tick_count), .stall(stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               at;
        logic [CNT_W-1:0] rem;
        logic             bsy;
    } done_exp_t;

    int        exp_tick[$];
    done_exp_t exp_done[$];
    int        total = 0;
    int        bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every tick_pulse/done the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (tick_pulse) begin
                if (exp_tick.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tick_unexpected: got tick_pulse at cycle %0d expected none", cyc);
                end else begin
                    check("tick_cycle", cyc, exp_tick.pop_front());
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
                end else begin
                    done_exp_t e;
                    e = exp_done.pop_front();
                    check("done_cycle", cyc, e.at);
                    check("done_remaining", remaining, e.rem);
                    check("done_busy", busy, e.bsy);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Toggle the timebase now; its tick_pulse is due 3 cycles later. Returns the toggle cycle.
    task automatic toggle(output int t);
        t = cyc;
        tick_in = ~tick_in;
        exp_tick.push_back(t + 3);
    endtask

    task automatic pulse_start(input logic [CNT_W-1:0] lv, input logic rl, output int s);
        s        = cyc;
        start    = 1'b1;
        load_val = lv;
        reload   = rl;
        step(1);
        start    = 1'b0;
    endtask

    task automatic push_done(input int at, input logic [CNT_W-1:0] rem, input logic bsy);
        done_exp_t e;
        e.at = at; e.rem = rem; e.bsy = bsy;
        exp_done.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t, s;
        rst = 1'b1; tick_in = 1'b0; start = 1'b0; load_val = '0; reload = 1'b0; abort = 1'b0;

        // Reset values.
        step(2);
        check("rst_tick_pulse", tick_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_remaining", remaining, 0);
        check("rst_tick_count", tick_count, 0);
        check("rst_stall", stall, 0);
        rst = 1'b0;
        step(2);

        // Five free ticks, no countdown running.
        for (int i = 0; i < 5; i++) begin
            toggle(t);
            step(10);
        end
        check("free_tick_count", tick_count, 5);
        check("free_busy", busy, 0);
        check("free_remaining", remaining, 0);

        // One-shot of 3 ticks.
        pulse_start(3, 1'b0, s);
        check("os_busy", busy, 1);
        check("os_remaining0", remaining, 3);
        for (int i = 1; i <= 3; i++) begin
            toggle(t);
            if (i == 3) push_done(t + 4, 0, 1'b0);
            step(10);
            check("os_remaining", remaining, 3 - i);
        end
        check("os_busy_end", busy, 0);
        check("os_tick_count", tick_count, 8);

        // Auto-reload of 2 ticks: done after ticks 2, 4, 6.
        pulse_start(2, 1'b1, s);
        for (int i = 1; i <= 6; i++) begin
            toggle(t);
            if (i % 2 == 0) push_done(t + 4, 2, 1'b1);
            step(10);
            check("ar_remaining", remaining, (i % 2 == 0) ? 2 : 1);
            check("ar_busy", busy, 1);
        end
        abort = 1'b1; step(1); abort = 1'b0;
        check("ar_abort_busy", busy, 0);
        check("ar_abort_remaining", remaining, 0);

        // Abort mid-count produces no done; zero load gives a single done.
        pulse_start(4, 1'b0, s);
        for (int i = 0; i < 2; i++) begin
            toggle(t);
            step(10);
        end
        check("ab_remaining", remaining, 2);
        abort = 1'b1; step(1); abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_remaining_end", remaining, 0);
        step(5);
        pulse_start(0, 1'b0, s);
        push_done(s + 1, 0, 1'b0);
        step(5);
        check("zero_busy", busy, 0);
        check("zero_remaining", remaining, 0);

        // Restart coinciding with the final tick: the tick is ignored, no done.
        pulse_start(2, 1'b0, s);
        toggle(t);
        step(10);
        check("rs_remaining1", remaining, 1);
        toggle(t);
        step(3);
        start = 1'b1; load_val = 7; reload = 1'b0;
        step(1);
        start = 1'b0;
        step(2);
        check("rs_remaining", remaining, 7);
        check("rs_busy", busy, 1);
        step(5);

        // Asynchronous reset mid-count clears everything without a clock edge.
        #2;
        rst = 1'b1;
        tick_in = 1'b0;
        #1;
        check("amr_busy", busy, 0);
        check("amr_done", done, 0);
        check("amr_remaining", remaining, 0);
        check("amr_tick_count", tick_count, 0);
        check("amr_tick_pulse", tick_pulse, 0);
        check("amr_stall", stall, 0);
        step(2);
        rst = 1'b0;
        step(3);
        check("amr_busy_after", busy, 0);

        // Stall watchdog (STALL_CYCLES=50): raised 50 cycles after the clearing tick.
        toggle(t);
        step(53);
        check("stall_before", stall, 0);
        step(1);
        check("stall_set", stall, STALL_EN);
        step(6);
        check("stall_hold", stall, STALL_EN);
        check("stall_no_effect_busy", busy, 0);
        toggle(t);
        step(3);
        check("stall_at_tick", stall, STALL_EN);
        step(1);
        check("stall_cleared", stall, 0);

        step(10);
        check("tick_q_empty", exp_tick.size(), 0);
        check("done_q_empty", exp_done.size(), 0);
        check("final_tick_count", tick_count, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tick_countdown_timer.md
Name: tick_countdown_timer

Overview:
- Consumes the slow toggling timebase produced by the clock-divider blocks (e.g. the 1 ms toggle) and converts it back into single-cycle tick strobes in the fast clock domain.
- Provides a programmable countdown with start/abort/done handshake, used by game logic for ghost-mode durations, power-pellet timeouts and frame pacing.
- Supports one-shot and auto-reload modes.
- Keeps a free-running tick counter for debug and RNG seeding.

Parameters:
- CNT_W, 16, width of countdown load value and remaining count.
- FREE_W, 32, width of the free-running tick counter.
- STALL_CYCLES, 1200000, fast-clock cycles without a tick_in toggle before stall is flagged (optional feature only).

Ports:
- clk  in  1  fast system clock.
- rst  in  1  asynchronous reset, active-high.
- tick_in  in  1  toggling timebase from the divider; asynchronous to clk.
- start  in  1  one-cycle strobe; loads load_val and begins counting.
- load_val  in  CNT_W  number of ticks to count, sampled only when start=1.
- reload  in  1  1 = auto-reload on expiry; sampled with start.
- abort  in  1  one-cycle strobe; cancels the countdown.
- tick_pulse  out  1  one-cycle strobe for each tick_in edge, rising or falling.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle strobe on expiry.
- remaining  out  CNT_W  current remaining count.
- tick_count  out  FREE_W  free-running count of tick_pulse.
- stall  out  1  timebase-stall flag (optional feature; tied 0 otherwise).

Behaviour:
- Reset values (async on rst=1): sync flops=0, edge reference=0, tick_pulse=0, busy=0, done=0, remaining=0, tick_count=0, stall=0, state=IDLE, reload flag=0.
- Synchronizer and edge detect:
  - tick_in passes through a 2-flop synchronizer, then a third flop holds the previous value.
  - tick_pulse = sync2 XOR prev, registered.
  - tick_pulse asserts exactly 3 clk cycles after a tick_in transition and lasts 1 cycle.
  - Each toggle is one tick; both edges count.
- tick_count increments by 1 on every tick_pulse, in any state, and wraps modulo 2^FREE_W.
- State machine (2 states):
  - IDLE: busy=0.
    - start with load_val>0: remaining<=load_val, latch reload, go to RUN.
    - start with load_val=0: done pulses the next cycle, remaining stays 0, stay in IDLE.
  - RUN: busy=1. On tick_pulse:
    - remaining>1: decrement.
    - remaining==1: done pulses the next cycle.
      - reload=1: remaining<=the load_val latched at start, stay in RUN.
      - reload=0: remaining<=0, go to IDLE.
- Priority within a cycle: abort > start > tick_pulse.
  - abort in any state: go to IDLE, remaining<=0, no done pulse.
  - start in RUN restarts with the new load_val; a tick_pulse in the same cycle is ignored.
- done is registered; it is never high for two consecutive cycles unless a one-tick auto-reload sees ticks on consecutive cycles, which cannot occur given synchronizer spacing.
- Reset mid-count: all state cleared immediately; no done is produced.
- Arithmetic: all counters unsigned; remaining never underflows below 0.

Optional Feature:
- Macro: TICK_STALL_DETECT_EN.
- Defined:
  - A watchdog counter, width ceil(log2(STALL_CYCLES+1)), clears on every tick_pulse and otherwise increments, saturating at STALL_CYCLES.
  - stall=1 while watchdog==STALL_CYCLES; it clears on the cycle after the next tick_pulse.
  - stall does not affect the countdown.
- Undefined: no watchdog logic; stall tied to 0.

Test Plan:
- Reset, then toggle tick_in 5 times every 10 clk -> 5 tick_pulses, each 3 cycles after its toggle, tick_count=5, all other outputs at reset values.
- start with load_val=3, reload=0, then 3 toggles -> busy=1, remaining 3->2->1, done pulses once after the 3rd tick_pulse, busy=0, remaining=0.
- start with load_val=2, reload=1, then 6 toggles -> done pulses after ticks 2, 4, 6; busy stays 1; remaining reloads to 2 each time.
- start load_val=4, 2 ticks, abort -> busy=0, remaining=0, no done; start with load_val=0 -> single done, busy stays 0.
- In RUN with remaining=1, assert start with load_val=7 in the same cycle as a tick_pulse -> no done, remaining=7; assert rst mid-count -> all outputs 0 asynchronously.
- With TICK_STALL_DETECT_EN and STALL_CYCLES=50: hold tick_in for 60 cycles -> stall=1 from cycle 50; one toggle -> stall=0 after the tick_pulse. Without the macro -> stall stays 0.
